// File: rtl/sw_debounce_capture_if.sv
// ---------------------------------------------------------------------------
// sw_debounce_capture_if
// Event snapshot handshake between the switch conditioner (master) and its
// consumer (slave).
//   evt_valid   : a captured sw_clean snapshot is pending on evt_data
//   evt_data    : snapshot taken at the most recent accepted change
//   evt_ready   : consumer acknowledges evt_data
//   evt_overrun : sticky, a change was captured while an event was pending
// ---------------------------------------------------------------------------
interface sw_debounce_capture_if #(
  parameter int WIDTH = 8
);
  logic             evt_valid;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ready;
  logic             evt_overrun;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_overrun,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_overrun,
    output evt_ready
  );
endinterface

// File: rtl/sw_debounce_capture.sv
// ---------------------------------------------------------------------------
// sw_debounce_capture
// Conditions WIDTH asynchronous slide-switch inputs: two-flop synchronizer,
// optional per-bit debounce FSM, edge pulses and a single-entry snapshot
// register with valid/ready handshake and a sticky overrun flag.
//
// Ports:
//   clk       : sole clock
//   rst       : synchronous active-high reset
//   sw_raw    : raw asynchronous switch levels
//   sw_clean  : conditioned switch levels
//   sw_rise   : one-cycle pulse per bit on sw_clean 0->1
//   sw_fall   : one-cycle pulse per bit on sw_clean 1->0
//   evt       : snapshot handshake (master modport of sw_debounce_capture_if)
//
// Configuration macro SW_DEBOUNCE_EN:
//   defined   -> each bit must be stable for DEBOUNCE_CYCLES cycles before
//                sw_clean follows it (latency 2 + DEBOUNCE_CYCLES edges)
//   undefined -> sw_clean is the synchronizer output (latency 2 edges) and
//                DEBOUNCE_CYCLES has no effect
// ---------------------------------------------------------------------------
module sw_debounce_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      sw_raw,
  output logic [WIDTH-1:0]      sw_clean,
  output logic [WIDTH-1:0]      sw_rise,
  output logic [WIDTH-1:0]      sw_fall,
  sw_debounce_capture_if.master evt
);

  // Elaboration-time range guard for the settle length.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777216) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES out of range 2..2^24");
  end

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync2_q, sync2_d;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  // Second synchronizer stage and per-bit debounce next-state logic.
  always_comb begin
    sync2_d = sync1_q;
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != clean_q[i]) begin
            state_d[i] = ST_SETTLING;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else begin
            state_d[i] = ST_STABLE;
          end
        end
        ST_SETTLING: begin
          if (sync2_q[i] == clean_q[i]) begin
            // Glitch: input returned before the settle completed.
            state_d[i] = ST_STABLE;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else if ((cnt_q[i] + 1'b1) == CNT_DONE) begin
            // Counter reaches DEBOUNCE_CYCLES-1 on this edge: accept level.
            clean_d[i] = sync2_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Debounce state, counters and second synchronizer stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync2_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      sync2_q <= sync2_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
`else
  // Without debouncing the clean register is the second synchronizer stage.
  always_comb begin
    clean_d = sync1_q;
  end
`endif

  // First synchronizer stage and edge pulses aligned with the new clean level.
  always_comb begin
    sync1_d = sw_raw;
    rise_d  = clean_d & ~clean_q;
    fall_d  = ~clean_d & clean_q;
  end

  // Snapshot handshake: any pulse this cycle is one event for all bits.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if ((rise_q | fall_q) != {WIDTH{1'b0}}) begin
      data_d  = clean_q;
      valid_d = 1'b1;
      if (valid_q && !evt.evt_ready) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (valid_q && evt.evt_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Synchronizer, clean level, pulses and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {WIDTH{1'b0}};
      clean_q <= {WIDTH{1'b0}};
      rise_q  <= {WIDTH{1'b0}};
      fall_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sw_clean        = clean_q;
  assign sw_rise         = rise_q;
  assign sw_fall         = fall_q;
  assign evt.evt_valid   = valid_q;
  assign evt.evt_data    = data_q;
  assign evt.evt_overrun = ovr_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_capture
// Self-checking bench for sw_debounce_capture (WIDTH=8, DEBOUNCE_CYCLES=4).
// Each accepted level change is pushed to a scoreboard queue with the cycle
// at which sw_clean must show it; a negedge monitor pops it on that cycle and
// checks sw_clean / sw_rise / sw_fall, and keeps a small handshake model for
// evt_valid / evt_data / evt_overrun. Adapts to SW_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_sw_debounce_capture;

  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;
`ifdef SW_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT = DEB ? (2 + DEBOUNCE) : 2;

  typedef struct {
    int         due;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] sw_clean, sw_rise, sw_fall;

  sw_debounce_capture_if #(.WIDTH(WIDTH)) evt_if ();

  sw_debounce_capture #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;
  rec_t sb[$];
  logic [7:0] tgt = 8'h00;

  // Expected outputs for the current cycle.
  logic [7:0] exp_clean = 8'h00, exp_rise = 8'h00, exp_fall = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0, exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive a new raw level; if it must be accepted, schedule its expectation.
  task automatic drive(input logic [7:0] v, input bit accept);
    rec_t r;
    sw_raw = v;
    if (accept) begin
      r.due   = cyc + LAT;
      r.clean = v;
      r.rise  = v & ~tgt;
      r.fall  = ~v & tgt;
      sb.push_back(r);
      tgt = v;
    end
  endtask

  // Monitor: compare every cycle, then advance the handshake model.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_rise = 8'h00;
        exp_fall = 8'h00;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          r = sb.pop_front();
          exp_clean = r.clean;
          exp_rise  = r.rise;
          exp_fall  = r.fall;
        end
        chk("sw_clean", sw_clean, exp_clean);
        chk("sw_rise", sw_rise, exp_rise);
        chk("sw_fall", sw_fall, exp_fall);
        chk("evt_valid", evt_if.evt_valid, exp_valid);
        chk("evt_data", evt_if.evt_data, exp_data);
        chk("evt_overrun", evt_if.evt_overrun, exp_ovr);
        if (rst) begin
          exp_clean = 8'h00;
          exp_data  = 8'h00;
          exp_valid = 1'b0;
          exp_ovr   = 1'b0;
          sb.delete();
        end else if ((exp_rise | exp_fall) != 8'h00) begin
          exp_ovr   = exp_ovr | (exp_valid & ~evt_if.evt_ready);
          exp_data  = exp_clean;
          exp_valid = 1'b1;
        end else if (exp_valid && evt_if.evt_ready) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    evt_if.evt_ready = 1'b0;
    // Reset held three cycles with switches low.
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;

    // Single bit rise, then acknowledge.
    drive(8'h01, 1'b1);
    tick(LAT + 2);
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    tick(2);

    // Short glitches: rejected when debouncing, propagated otherwise.
    evt_if.evt_ready = 1'b1;
    drive(8'h05, !DEB);
    tick(3);
    drive(8'h01, !DEB);
    tick(LAT + 4);
    drive(8'h11, !DEB);
    tick(1);
    drive(8'h01, !DEB);
    tick(LAT + 4);

    // Pulse exactly DEBOUNCE cycles wide is accepted in both directions.
    drive(8'h05, 1'b1);
    tick(DEBOUNCE);
    drive(8'h01, 1'b1);
    tick(LAT + 3);
    drive(8'h00, 1'b1);
    tick(LAT + 3);
    evt_if.evt_ready = 1'b0;
    tick(2);

    // Two bits change together: one event.
    drive(8'h81, 1'b1);
    tick(LAT + 2);
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    tick(1);

    // Ready asserted in the cycle a new change lands: no overrun.
    drive(8'h01, 1'b1);
    tick(LAT + 2);
    drive(8'h03, 1'b1);
    tick(LAT);
    evt_if.evt_ready = 1'b1;
    tick(1);
    evt_if.evt_ready = 1'b0;
    tick(2);

    // Clear pending event, then two unacknowledged changes: overrun.
    evt_if.evt_ready = 1'b1;
    drive(8'h00, 1'b1);
    tick(LAT + 2);
    evt_if.evt_ready = 1'b0;
    drive(8'h01, 1'b1);
    tick(LAT + 2);
    drive(8'h03, 1'b1);
    tick(LAT + 6);

    // Reset in the middle of a settle, switches stay high across reset.
    drive(8'hFF, 1'b1);
    tick(1);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tgt = 8'h00;
    drive(8'hFF, 1'b1);
    tick(LAT + 4);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
